// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pixel counters, display enable, delayed active-low syncs,
// plus a frame-start pulse and frame counter for game logic.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DLY_W   = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             blank_q, blank_d;
  logic             hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
  logic [DLY_W-1:0] hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_count_q, frame_count_d;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    blank_d       = blank_q;
    hs_raw_d      = hs_raw_q;
    vs_raw_d      = vs_raw_q;
    hs_dly_d      = hs_dly_q;
    vs_dly_d      = vs_dly_q;
    frame_start_d = frame_start_q;
    frame_count_d = frame_count_q;

    if (pix_en) begin
      frame_start_d = 1'b0;
      // >= comparisons also pull any out-of-range count back to zero
      if (x_q >= H_LAST) begin
        x_d = '0;
        if (y_q >= V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
        if (y_q > V_LAST) y_d = '0;
      end

      // Decoded from next-state so they line up with the registered counters
      blank_d  = (x_d < H_VIS) && (y_d < V_VIS);
      hs_raw_d = !((x_d >= HS_START) && (x_d < HS_END));
      vs_raw_d = !((y_d >= VS_START) && (y_d < VS_END));

      hs_dly_d[0] = hs_raw_q;
      vs_dly_d[0] = vs_raw_q;
      for (int i = 1; i < DLY_W; i++) begin
        hs_dly_d[i] = hs_dly_q[i-1];
        vs_dly_d[i] = vs_dly_q[i-1];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      hs_dly_q      <= '1;
      vs_dly_q      <= '1;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      hs_dly_q      <= hs_dly_d;
      vs_dly_q      <= vs_dly_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_dly
      assign hs = hs_raw_q;
      assign vs = vs_raw_q;
    end else begin : g_dly
      assign hs = hs_dly_q[DLY_W-1];
      assign vs = vs_dly_q[DLY_W-1];
    end
  endgenerate

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a tiny-frame instance, both
// checked every cycle against an arithmetic model indexed by enabled-edge count.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bl;
    logic        h;
    logic        v;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en = 1'b0;

  logic [9:0]  dx, dy, sx, sy;
  logic        dbl, dhs, dvs, dfs, sbl, shs, svs, sfs;
  logic [15:0] dfc, sfc;

  int checks = 0;
  int failures = 0;
  int e = 0;  // enabled edges since last reset

  vga_timing_gen dut (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(dx), .DrawY(dy), .blank(dbl), .hs(dhs), .vs(dvs),
    .frame_start(dfs), .frame_count(dfc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_DELAY(3)
  ) dut_s (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(sx), .DrawY(sy), .blank(sbl), .hs(shs), .vs(svs),
    .frame_start(sfs), .frame_count(sfc)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) e <= 0;
    else if (pix_en) e <= e + 1;

  // Outputs after n enabled edges, derived from the raster geometry directly.
  function automatic exp_t model(input int n, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb, input int sd);
    exp_t r;
    int ht, vt, t, pos, x, y, k;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    t  = ht * vt;
    if (n == 0) begin
      r.x = '0; r.y = '0; r.bl = 1'b0; r.fs = 1'b0; r.fc = '0;
    end else begin
      pos  = n % t;
      x    = pos % ht;
      y    = pos / ht;
      r.x  = 10'(x);
      r.y  = 10'(y);
      r.bl = (x < hv) && (y < vv);
      r.fs = (pos == 0);
      r.fc = 16'((n / t) % 65536);
    end
    k = n - sd;
    if (k <= 0) begin
      r.h = 1'b1; r.v = 1'b1;
    end else begin
      pos = k % t;
      x   = pos % ht;
      y   = pos / ht;
      r.h = !((x >= hv + hf) && (x < hv + hf + hsw));
      r.v = !((y >= vv + vf) && (y < vv + vf + vsw));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t gd, gs, ed, es;
    gd = {dx, dy, dbl, dhs, dvs, dfs, dfc};
    gs = {sx, sy, sbl, shs, svs, sfs, sfc};
    ed = model(e, 640, 16, 96, 48, 480, 10, 2, 33, 2);
    es = model(e, 8, 2, 3, 2, 6, 1, 2, 2, 3);
    checks++;
    if (gd !== ed) begin
      failures++;
      $display("FAIL cycle_full e=%0d got=%h exp=%h", e, gd, ed);
    end
    checks++;
    if (gs !== es) begin
      failures++;
      $display("FAIL cycle_small e=%0d got=%h exp=%h", e, gs, es);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    pix_en = 1'b1;
    while (e < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (e != target) begin
      failures++;
      $display("FAIL goto_timeout got=%0d exp=%0d", e, target);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(dx), 0);
    chk({tag, "_y"}, 32'(dy), 0);
    chk({tag, "_blank"}, 32'(dbl), 0);
    chk({tag, "_hs"}, 32'(dhs), 1);
    chk({tag, "_vs"}, 32'(dvs), 1);
    chk({tag, "_fs"}, 32'(dfs), 0);
    chk({tag, "_fc"}, 32'(dfc), 0);
    chk({tag, "_small_fc"}, 32'(sfc), 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset_n = 1'b1;

    goto(1);
    chk("e1_x", 32'(dx), 1);
    chk("e1_y", 32'(dy), 0);
    chk("e1_blank", 32'(dbl), 1);
    goto(107);  chk("s_vs_107", 32'(svs), 1);
    goto(108);  chk("s_vs_108", 32'(svs), 0);
    goto(137);  chk("s_vs_137", 32'(svs), 0);
    goto(138);  chk("s_vs_138", 32'(svs), 1);
    goto(165);
    chk("s_wrap_x", 32'(sx), 0);
    chk("s_wrap_y", 32'(sy), 0);
    chk("s_wrap_fs", 32'(sfs), 1);
    chk("s_wrap_fc", 32'(sfc), 1);
    goto(166);  chk("s_fs_166", 32'(sfs), 0);
    goto(330);  chk("s_fc_330", 32'(sfc), 2);
    goto(640);
    chk("e640_x", 32'(dx), 640);
    chk("e640_blank", 32'(dbl), 0);
    goto(657);  chk("hs_657", 32'(dhs), 1);
    goto(658);  chk("hs_658", 32'(dhs), 0);
    goto(753);  chk("hs_753", 32'(dhs), 0);
    goto(754);  chk("hs_754", 32'(dhs), 1);
    goto(800);
    chk("e800_x", 32'(dx), 0);
    chk("e800_y", 32'(dy), 1);
    goto(1458); chk("hs_1458", 32'(dhs), 0);

    for (int i = 0; i < 15000; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    async_reset();
    for (int c = 1; c <= 1320; c++) begin
      pix_en = (c % 2 == 0);
      @(negedge clk);
      if (c == 1000) chk("tog_x_1000", 32'(dx), 500);
      if (c == 1315) chk("tog_hs_1315", 32'(dhs), 1);
      if (c == 1316) chk("tog_hs_1316", 32'(dhs), 0);
    end
    pix_en = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold_x", 32'(dx), 660);
    chk("hold_hs", 32'(dhs), 0);

    async_reset();
    goto(40300);
    chk("mid_x", 32'(dx), 300);
    chk("mid_y", 32'(dy), 50);
    async_reset();
    goto(1);
    chk("rel_x", 32'(dx), 1);
    chk("rel_y", 32'(dy), 0);
    chk("rel_fc", 32'(dfc), 0);
    chk("rel_fs", 32'(dfs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
